// File: rtl/usb_fs_out_drain_arb_if.sv
// usb_fs_out_drain_arb_if: endpoint-side handshake and downstream byte stream of the OUT drain arbiter.
interface usb_fs_out_drain_arb_if #(
   parameter int NUM_OUT_EPS = 4
);
   logic [NUM_OUT_EPS-1:0] ep_enable;
   logic [NUM_OUT_EPS-1:0] out_ep_data_avail;
   logic [NUM_OUT_EPS-1:0] out_ep_setup;
   logic [NUM_OUT_EPS-1:0] out_ep_data_get;
   logic [7:0]             out_ep_data;
   logic                   m_valid;
   logic                   m_ready;
   logic [7:0]             m_data;
   logic [3:0]             m_ep;
   logic                   m_first;
   logic                   m_last;
   logic                   m_setup;
   logic                   busy;
   modport master (
      input  ep_enable, out_ep_data_avail, out_ep_setup, out_ep_data, m_ready,
      output out_ep_data_get, m_valid, m_data, m_ep, m_first, m_last, m_setup, busy
   );
   modport slave (
      output ep_enable, out_ep_data_avail, out_ep_setup, out_ep_data, m_ready,
      input  out_ep_data_get, m_valid, m_data, m_ep, m_first, m_last, m_setup, busy
   );
endinterface

// File: rtl/usb_fs_out_drain_arb.sv
// usb_fs_out_drain_arb: round-robin arbiter draining OUT endpoint buffers into a
// 2-entry byte stream tagged with first/last/SETUP.
module usb_fs_out_drain_arb #(
   parameter int NUM_OUT_EPS = 4
) (
   input logic clk,
   input logic reset,
   usb_fs_out_drain_arb_if.master bus
);
   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;
   state_t      state_q, state_d;
   logic [3:0]  last_grant_q, last_grant_d, ep_q, ep_d, grant, idx;
   logic        setup_q, setup_d, first_q, first_d, pending_q;
   logic        found, pop, get_ok;
   logic [1:0]  count_q, count_d;
   logic        rd_q, wr_q;
   logic [9:0]  mem_q [2];
   logic [9:0]  head;
   logic [15:0] req16, avail16, setup16;

   assign req16   = 16'(bus.out_ep_data_avail & bus.ep_enable);
   assign avail16 = 16'(bus.out_ep_data_avail);
   assign setup16 = 16'(bus.out_ep_setup);
   assign head    = mem_q[rd_q];
   assign pop     = (count_q != 2'd0) && bus.m_ready;
   // Fill counts the pop of this cycle so a full-rate stream keeps one get per cycle.
   assign get_ok  = (state_q == DRAIN) && !reset && avail16[ep_q] &&
                    (3'(count_q) + 3'(pending_q) - 3'(pop) < 3'd2);

   always_comb begin
      grant = 4'd0;
      found = 1'b0;
      idx   = 4'd0;
      for (int i = 1; i <= NUM_OUT_EPS; i++) begin
         idx = 4'((int'(last_grant_q) + i) % NUM_OUT_EPS);
         if (!found && req16[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      ep_d         = ep_q;
      setup_d      = setup_q;
      first_d      = pending_q ? 1'b0 : first_q;
      count_d      = count_q + 2'(pending_q) - 2'(pop);
      if (state_q == IDLE && found) begin
         state_d      = DRAIN;
         last_grant_d = grant;
         ep_d         = grant;
         setup_d      = setup16[grant];
         first_d      = 1'b1;
      end
      if (state_q == DRAIN && pending_q && !avail16[ep_q]) state_d = FLUSH;
      if (state_q == FLUSH && pop && head[8]) state_d = IDLE;
   end

   always_comb begin
      bus.out_ep_data_get = '0;
      for (int i = 0; i < NUM_OUT_EPS; i++) bus.out_ep_data_get[i] = get_ok && (ep_q == 4'(i));
   end

   assign bus.m_valid = count_q != 2'd0;
   assign bus.m_data  = head[7:0];
   assign bus.m_first = bus.m_valid && head[9];
   assign bus.m_last  = bus.m_valid && head[8];
   assign bus.m_ep    = ep_q;
   assign bus.m_setup = setup_q;
   assign bus.busy    = state_q != IDLE;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 4'(NUM_OUT_EPS - 1);
         ep_q         <= 4'd0;
         setup_q      <= 1'b0;
         first_q      <= 1'b0;
         pending_q    <= 1'b0;
         count_q      <= 2'd0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         mem_q[0]     <= '0;
         mem_q[1]     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         ep_q         <= ep_d;
         setup_q      <= setup_d;
         first_q      <= first_d;
         pending_q    <= get_ok;
         count_q      <= count_d;
         if (pending_q) begin
            mem_q[wr_q] <= {first_q, ~avail16[ep_q], bus.out_ep_data};
            wr_q        <= ~wr_q;
         end
         if (pop) rd_q <= ~rd_q;
      end
   end
endmodule

// File: tb/tb_usb_fs_out_drain_arb.sv
// tb_usb_fs_out_drain_arb: directed packets through a behavioural OUT engine; a monitor
// checks every accepted beat against a scoreboard of expected bytes.
module tb_usb_fs_out_drain_arb;
   localparam int N = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   usb_fs_out_drain_arb_if #(.NUM_OUT_EPS(N)) bus ();
   usb_fs_out_drain_arb #(.NUM_OUT_EPS(N)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] ep;
      logic       setup;
      logic       first;
      logic       last;
      logic [7:0] data;
   } beat_t;
   beat_t sb[$];
   beat_t act_b, exp_b;
   int vectors = 0, errs = 0, cyc = 0, xfers = 0, first_xfer = 0, last_xfer = 0, outstanding = 0;
   logic [7:0] emem [N][64];
   int hd [N];
   int tl [N];
   logic [N-1:0] gs;
   logic ready_toggle = 1'b0;
   logic pop_now;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic load(input int ep, input int n, input logic [7:0] base, input logic setup);
      for (int i = 0; i < n; i++) begin
         emem[ep][tl[ep]] = base + 8'(i);
         tl[ep]++;
      end
      bus.out_ep_setup[ep] = setup;
      bus.out_ep_data_avail[ep] = 1'b1;
   endtask

   task automatic expect_pkt(input int ep, input int n, input logic [7:0] base, input logic setup);
      for (int i = 0; i < n; i++) sb.push_back(beat_t'{4'(ep), setup, i == 0, i == n - 1, base + 8'(i)});
   endtask

   task automatic clear_engine();
      for (int e = 0; e < N; e++) hd[e] = tl[e];
      bus.out_ep_data_avail = '0;
   endtask

   task automatic wait_idle(output int idle_cyc);
      idle_cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #2;
         if (!bus.busy && !bus.m_valid && sb.size() == 0) begin
            idle_cyc = cyc;
            return;
         end
      end
      vectors++;
      errs++;
      $display("FAIL idle timeout: %0d beats still expected", sb.size());
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      bus.m_ready = ready_toggle ? ~bus.m_ready : 1'b1;
   end

   // OUT engine model: a get seen in one cycle delivers its byte and updated avail in the next.
   initial forever begin
      @(negedge clk);
      gs = bus.out_ep_data_get;
      @(posedge clk);
      #1;
      for (int e = 0; e < N; e++)
         if (gs[e] && hd[e] != tl[e]) begin
            bus.out_ep_data = emem[e][hd[e]];
            hd[e]++;
            bus.out_ep_data_avail[e] = hd[e] != tl[e];
         end
   end

   initial forever begin
      @(negedge clk);
      if (reset) outstanding = 0;
      else begin
         pop_now = bus.m_valid && bus.m_ready;
         if (bus.out_ep_data_get != '0) begin
            chk("get onehot on granted ep", 32'(bus.out_ep_data_get), 32'(1) << bus.m_ep);
            chk("get only when avail", 32'(bus.out_ep_data_get & ~bus.out_ep_data_avail), 0);
            chk("get with fill below 2", 32'(outstanding - int'(pop_now) < 2), 1);
         end
         if (pop_now) begin
            xfers++;
            last_xfer = cyc;
            if (bus.m_first) first_xfer = cyc;
            act_b = {bus.m_ep, bus.m_setup, bus.m_first, bus.m_last, bus.m_data};
            if (sb.size() == 0) begin
               vectors++;
               errs++;
               $display("FAIL unexpected beat: got 0x%0h, expected none", act_b);
            end else begin
               exp_b = sb.pop_front();
               chk("beat {ep,setup,first,last,data}", 32'(act_b), 32'(exp_b));
            end
         end
         outstanding += int'(bus.out_ep_data_get != '0) - int'(pop_now);
      end
   end

   initial begin
      int t0, idle;
      bus.ep_enable = '1;
      bus.out_ep_data_avail = '0;
      bus.out_ep_setup = '0;
      bus.out_ep_data = 8'h00;
      bus.m_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset get", 32'(bus.out_ep_data_get), 0);
      chk("reset m_valid", 32'(bus.m_valid), 0);
      chk("reset m_first", 32'(bus.m_first), 0);
      chk("reset m_last", 32'(bus.m_last), 0);
      chk("reset m_setup", 32'(bus.m_setup), 0);
      chk("reset m_ep", 32'(bus.m_ep), 0);
      chk("reset m_data", 32'(bus.m_data), 0);
      chk("reset busy", 32'(bus.busy), 0);
      #2 reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("no avail no grant", 32'(bus.busy), 0);
      chk("no avail no get", 32'(bus.out_ep_data_get), 0);
      #2;
      t0 = cyc;
      load(1, 3, 8'hA1, 1'b0);
      expect_pkt(1, 3, 8'hA1, 1'b0);
      wait_idle(idle);
      chk("ep1 first beat latency", 32'(first_xfer - t0), 3);
      chk("ep1 back-to-back beats", 32'(last_xfer - first_xfer), 2);
      chk("ep1 busy falls after last", 32'(idle - last_xfer), 1);
      load(0, 1, 8'h5A, 1'b0);
      expect_pkt(0, 1, 8'h5A, 1'b0);
      wait_idle(idle);
      load(0, 2, 8'h10, 1'b0);
      load(2, 3, 8'h20, 1'b0);
      expect_pkt(2, 3, 8'h20, 1'b0);
      expect_pkt(0, 2, 8'h10, 1'b0);
      wait_idle(idle);
      load(0, 1, 8'h30, 1'b0);
      load(2, 2, 8'h40, 1'b0);
      expect_pkt(2, 2, 8'h40, 1'b0);
      expect_pkt(0, 1, 8'h30, 1'b0);
      wait_idle(idle);
      ready_toggle = 1'b1;
      load(3, 8, 8'hC0, 1'b1);
      expect_pkt(3, 8, 8'hC0, 1'b1);
      wait_idle(idle);
      ready_toggle = 1'b0;
      @(negedge clk);
      #2;
      load(1, 5, 8'hB0, 1'b0);
      sb.push_back(beat_t'{4'd1, 1'b0, 1'b1, 1'b0, 8'hB0});
      sb.push_back(beat_t'{4'd1, 1'b0, 1'b0, 1'b0, 8'hB1});
      t0 = xfers;
      for (int i = 0; i < 50 && xfers < t0 + 2; i++) begin
         @(negedge clk);
         #2;
      end
      chk("two beats before reset", 32'(xfers - t0), 2);
      reset = 1'b1;
      #1;
      chk("no get in reset cycle", 32'(bus.out_ep_data_get), 0);
      @(posedge clk);
      #1;
      chk("m_valid after reset", 32'(bus.m_valid), 0);
      chk("get after reset", 32'(bus.out_ep_data_get), 0);
      chk("busy after reset", 32'(bus.busy), 0);
      @(negedge clk);
      #2;
      chk("get cycle after reset", 32'(bus.out_ep_data_get), 0);
      clear_engine();
      reset = 1'b0;
      load(2, 2, 8'hD0, 1'b0);
      expect_pkt(2, 2, 8'hD0, 1'b0);
      wait_idle(idle);
      bus.ep_enable = 4'b1101;
      load(1, 2, 8'hE0, 1'b0);
      repeat (5) @(negedge clk);
      chk("disabled ep not granted", 32'(bus.busy), 0);
      #2;
      bus.ep_enable = '1;
      expect_pkt(1, 2, 8'hE0, 1'b0);
      @(posedge clk);
      #1;
      chk("grant after enable", 32'(bus.busy), 1);
      bus.ep_enable = '0;
      wait_idle(idle);
      bus.ep_enable = '1;
      chk("scoreboard drained", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
